// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - operand, control and result bundle between EX stage and ex_muldiv
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] reg1_i;
    logic [XLEN-1:0] reg2_i;
    logic [4:0]      wd_i;
    logic            wreg_i;
    logic            flush_i;
    logic            stallreq_o;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] wdata_o;
    logic [4:0]      wd_o;
    logic            wreg_o;

    modport master (
        output start_i, funct3_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        input  stallreq_o, busy_o, valid_o, wdata_o, wd_o, wreg_o
    );

    modport slave (
        input  start_i, funct3_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        output stallreq_o, busy_o, valid_o, wdata_o, wd_o, wreg_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit; MDU_EARLY_OUT_EN enables zero/div-by-zero/overflow early out
module ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_step, prod;
    logic [XLEN-1:0]   opb;
    logic [2:0]        op;
    logic              neg, dz;
    logic [4:0]        wd_q, wd_out;
    logic              wreg_q, wreg_out;
    logic [XLEN-1:0]   wdata_q;

    logic              a_sgn, b_sgn, in_neg, accept;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     t, diff, sum;
    logic [XLEN-1:0]   mul_res, div_res, calc_res;
    logic              early;
    logic [XLEN-1:0]   early_res;

    assign accept = (state == IDLE) && bus.start_i && !bus.flush_i;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (bus.funct3_i)
            3'd1, 3'd4, 3'd6: begin
                a_sgn = bus.reg1_i[XLEN-1];
                b_sgn = bus.reg2_i[XLEN-1];
            end
            3'd2:    a_sgn = bus.reg1_i[XLEN-1];
            default: ;
        endcase
        a_mag  = a_sgn ? -bus.reg1_i : bus.reg1_i;
        b_mag  = b_sgn ? -bus.reg2_i : bus.reg2_i;
        // REM takes the dividend's sign; every other op the XOR of operand signs
        in_neg = (bus.funct3_i == 3'd6) ? a_sgn : (a_sgn ^ b_sgn);
    end

`ifdef MDU_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        early     = 1'b0;
        early_res = '0;
        if (bus.funct3_i[2]) begin
            if (bus.reg2_i == '0) begin
                early     = 1'b1;
                early_res = bus.funct3_i[1] ? bus.reg1_i : '1;
            end else if (!bus.funct3_i[0] && bus.reg1_i == MIN_NEG && bus.reg2_i == '1) begin
                early     = 1'b1;
                early_res = bus.funct3_i[1] ? '0 : MIN_NEG;
            end
        end else if (bus.reg1_i == '0 || bus.reg2_i == '0) begin
            early = 1'b1;
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // acc holds {partial product, multiplier} for multiply, {remainder, quotient} for divide
    always_comb begin
        acc_step = acc;
        t        = '0;
        diff     = '0;
        sum      = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (op[2]) begin
                t    = {acc_step[2*XLEN-1:XLEN], acc_step[XLEN-1]};
                diff = t - {1'b0, opb};
                if (!diff[XLEN])
                    acc_step = {diff[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
                else
                    acc_step = {t[XLEN-1:0], acc_step[XLEN-2:0], 1'b0};
            end else begin
                sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} + (acc_step[0] ? {1'b0, opb} : '0);
                acc_step = {sum, acc_step[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod     = neg ? -acc_step : acc_step;
        mul_res  = (op == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        if (op[1])
            div_res = neg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        else
            div_res = dz ? '1 : (neg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0]);
        calc_res = op[2] ? div_res : mul_res;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = early ? DONE : CALC;
            CALC:    if (bus.flush_i) state_next = IDLE;
                     else if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            op       <= '0;
            neg      <= 1'b0;
            dz       <= 1'b0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            wdata_q  <= '0;
            wd_out   <= '0;
            wreg_out <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (accept) begin
                    cnt    <= '0;
                    op     <= bus.funct3_i;
                    neg    <= in_neg;
                    dz     <= (bus.reg2_i == '0);
                    wd_q   <= bus.wd_i;
                    wreg_q <= bus.wreg_i;
                    acc    <= {{XLEN{1'b0}}, bus.funct3_i[2] ? a_mag : b_mag};
                    opb    <= bus.funct3_i[2] ? b_mag : a_mag;
                    if (early) begin
                        wdata_q  <= early_res;
                        wd_out   <= bus.wd_i;
                        wreg_out <= bus.wreg_i;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= acc_step;
                    if (!bus.flush_i && cnt == LAST) begin
                        wdata_q  <= calc_res;
                        wd_out   <= wd_q;
                        wreg_out <= wreg_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stallreq_o = accept || (state == CALC);
    assign bus.busy_o     = (state != IDLE);
    assign bus.valid_o    = (state == DONE);
    assign bus.wdata_o    = wdata_q;
    assign bus.wd_o       = wd_out;
    assign bus.wreg_o     = wreg_out;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv (UNROLL 1 and 4 instances)
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, flush = 1'b0, wreg = 1'b0, sel = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  wd = '0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32)) if1 ();
    ex_muldiv_if #(.XLEN(32)) if4 ();

    ex_muldiv #(.XLEN(32), .UNROLL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    ex_muldiv #(.XLEN(32), .UNROLL(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    assign if1.start_i = start & ~sel;  assign if4.start_i = start & sel;
    assign if1.funct3_i = f3;           assign if4.funct3_i = f3;
    assign if1.reg1_i = a;              assign if4.reg1_i = a;
    assign if1.reg2_i = b;              assign if4.reg2_i = b;
    assign if1.wd_i = wd;               assign if4.wd_i = wd;
    assign if1.wreg_i = wreg;           assign if4.wreg_i = wreg;
    assign if1.flush_i = flush;         assign if4.flush_i = flush;

    logic        d_valid, d_busy, d_stall, d_wreg;
    logic [31:0] d_wdata;
    logic [4:0]  d_wd;
    assign d_valid = sel ? if4.valid_o    : if1.valid_o;
    assign d_busy  = sel ? if4.busy_o     : if1.busy_o;
    assign d_stall = sel ? if4.stallreq_o : if1.stallreq_o;
    assign d_wdata = sel ? if4.wdata_o    : if1.wdata_o;
    assign d_wd    = sel ? if4.wd_o       : if1.wd_o;
    assign d_wreg  = sel ? if4.wreg_o     : if1.wreg_o;

    int checks = 0, fails = 0;
    int cyc = 0;
    int steps = 32;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] p;
        logic [63:0] pu;
        logic [31:0] r;
        case (f)
            3'd0: begin pu = {32'b0, x} * {32'b0, y}; r = pu[31:0]; end
            3'd1: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); r = p[63:32]; end
            3'd2: begin p = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); r = p[63:32]; end
            3'd3: begin pu = {32'b0, x} * {32'b0, y}; r = pu[63:32]; end
            3'd4: if (y == 0) r = 32'hFFFFFFFF;
                  else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
                  else r = $signed(x) / $signed(y);
            3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: if (y == 0) r = x;
                  else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 0;
                  else r = $signed(x) % $signed(y);
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic bit is_early(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
`ifdef MDU_EARLY_OUT_EN
        if (f[2]) return (y == 0) || ((f == 3'd4 || f == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF);
        return (x == 0) || (y == 0);
`else
        return (f == 3'd0) && (x !== x);
`endif
    endfunction

    // Transaction-level model: one pending op with the cycle its result must appear
    bit          m_busy = 0;
    int          m_due = 0;
    logic [31:0] m_res = 0, o_wdata = 0;
    logic [4:0]  m_wd = 0, o_wd = 0;
    logic        m_wreg = 0, o_wreg = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy <= 0; o_wdata <= 0; o_wd <= 0; o_wreg <= 0;
        end else if (m_busy) begin
            if (flush || cyc == m_due) m_busy <= 0;
            if (!flush && cyc + 1 == m_due) begin
                o_wdata <= m_res; o_wd <= m_wd; o_wreg <= m_wreg;
            end
        end else if (start && !flush) begin
            m_busy <= 1;
            m_res  <= ref_res(f3, a, b);
            m_wd   <= wd;
            m_wreg <= wreg;
            if (is_early(f3, a, b)) begin
                m_due   <= cyc + 1;
                o_wdata <= ref_res(f3, a, b); o_wd <= wd; o_wreg <= wreg;
            end else begin
                m_due <= cyc + 1 + steps;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_o", 32'(d_valid), 32'(m_busy && cyc == m_due));
            chk("busy_o", 32'(d_busy), 32'(m_busy));
            chk("stallreq_o", 32'(d_stall),
                32'((!m_busy && start && !flush) || (m_busy && cyc != m_due)));
            chk("wdata_o", d_wdata, o_wdata);
            chk("wd_o", 32'(d_wd), 32'(o_wd));
            chk("wreg_o", 32'(d_wreg), 32'(o_wreg));
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input string name);
        int k;
        bit got;
        @(posedge clk); #1;
        f3 = f; a = x; b = y; wd = 5'($urandom); wreg = 1'($urandom); start = 1; flush = 0;
        k = 0; got = 0;
        while (k < 100 && !got) begin
            @(negedge clk);
            if (d_valid) got = 1;
            else begin @(posedge clk); k++; end
        end
        if (!got) chk({name, " timeout"}, 32'(k), 32'(100 + 1));
        else begin
            chk(name, d_wdata, exp);
            chk({name, " latency"}, 32'(k), is_early(f, x, y) ? 32'd1 : 32'(steps + 1));
        end
        @(posedge clk); #1;
        start = 0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_op();
        int fa;
        @(posedge clk); #1;
        f3 = 3'($urandom_range(0, 7)); a = pick(); b = pick();
        wd = 5'($urandom); wreg = 1'($urandom);
        start = 1; flush = ($urandom_range(0, 9) == 0);
        @(posedge clk); #1;
        start = 0; flush = 0;
        fa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, steps + 1) : -1;
        for (int k = 0; k < steps + 3; k++) begin
            flush = (k == fa);
            @(posedge clk); #1;
            flush = 0;
        end
    endtask

    task automatic switch_dut(input logic s);
        @(posedge clk); #1;
        chk_en = 0; sel = s; rst = 1; start = 0; flush = 0;
        steps = s ? 8 : 32;
        @(posedge clk); #1;
        rst = 0; chk_en = 1;
    endtask

    localparam int NDIR = 14;
    logic [2:0]  t_f [NDIR] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6,
                                3'd4, 3'd6, 3'd4, 3'd6, 3'd0, 3'd0};
    logic [31:0] t_a [NDIR] = '{32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'd100, 32'd100,
                                32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000,
                                32'd3, 32'd0};
    logic [31:0] t_b [NDIR] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'd7, 32'd7,
                                32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd4, 32'd5};
    logic [31:0] t_e [NDIR] = '{32'hFFFFFFEB, 32'h40000000, 32'h40000000, 32'hFFFFFFFF, 32'd14, 32'd2,
                                32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0,
                                32'd12, 32'd0};

    initial begin
        for (int i = 0; i < NDIR; i++) chk($sformatf("model[%0d]", i), ref_res(t_f[i], t_a[i], t_b[i]), t_e[i]);

        repeat (3) @(posedge clk);
        #1 rst = 0; chk_en = 1;

        for (int s = 0; s < 2; s++) begin
            if (s == 1) switch_dut(1'b1);
            for (int i = 0; i < NDIR; i++) run_op(t_f[i], t_a[i], t_b[i], t_e[i], $sformatf("dir[%0d]", i));

            // flush mid-divide, then a fresh multiply
            @(posedge clk); #1;
            f3 = 3'd4; a = 32'd1000; b = 32'd3; start = 1;
            repeat (10) @(posedge clk);
            #1 flush = 1;
            @(posedge clk); #1;
            flush = 0; start = 0;
            @(negedge clk);
            chk("flush stallreq_o", 32'(d_stall), 32'd0);
            chk("flush busy_o", 32'(d_busy), 32'd0);
            run_op(3'd0, 32'd3, 32'd4, 32'd12, "mul after flush");

            // reset in the middle of a divide
            @(posedge clk); #1;
            f3 = 3'd4; a = 32'd77; b = 32'd5; start = 1;
            repeat (5) @(posedge clk);
            #1 rst = 1; start = 0;
            @(posedge clk); #1;
            rst = 0;
            @(negedge clk);
            chk("rst valid_o", 32'(d_valid), 32'd0);
            chk("rst busy_o", 32'(d_busy), 32'd0);
            chk("rst wdata_o", d_wdata, 32'd0);
            chk("rst wd_o", 32'(d_wd), 32'd0);
            chk("rst wreg_o", 32'(d_wreg), 32'd0);

            for (int i = 0; i < 50; i++) rand_op();
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
